// File: rtl/processor_pkg.sv
// Shared definitions for the 16-bit processor: default bus widths
// and the program loader state encoding.
package processor_pkg;

    localparam int PROC_DATA_WIDTH = 16;
    localparam int PROC_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        LD_LOAD,
        LD_HOLD,
        LD_RUN,
        LD_ERROR
    } loader_state_e;

endpackage

// File: rtl/program_loader.sv
// Boot sequencer: streams a program into IM from address 0 while the core
// is held in reset, then releases it and asserts cpu_start.
module program_loader
    import processor_pkg::*;
#(
    parameter int DATA_WIDTH   = PROC_DATA_WIDTH,
    parameter int ADDR_WIDTH   = PROC_ADDR_WIDTH,
    parameter int RESET_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  im_en_write,
    output logic [ADDR_WIDTH-1:0] im_address,
    output logic [DATA_WIDTH-1:0] im_data,
    output logic                  cpu_reset,
    output logic                  cpu_start,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  error
);

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

    loader_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    transfer;

    assign in_ready = (state_q == LD_LOAD) & ~reload;
    assign transfer = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        hold_d  = hold_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        if (reload) begin
            state_d = LD_LOAD;
            ptr_d   = '0;
            count_d = '0;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                LD_LOAD: begin
                    if (transfer) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        data_d  = in_data;
                        ptr_d   = ptr_q + ADDR_WIDTH'(1);
                        count_d = count_q + (ADDR_WIDTH + 1)'(1);
                        if (in_last) begin
                            state_d = LD_HOLD;
                            hold_d  = HOLD_INIT;
                        end else if (ptr_q == PTR_MAX) begin
                            state_d = LD_ERROR;
                        end
                    end
                end
                // Leave on the cycle the counter would reach zero.
                LD_HOLD: begin
                    if (hold_q <= HOLD_ONE) begin
                        state_d = LD_RUN;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q - HOLD_ONE;
                    end
                end
                LD_RUN:   ;
                LD_ERROR: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LD_LOAD;
            ptr_q   <= '0;
            count_q <= '0;
            hold_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign im_en_write = we_q;
    assign im_address  = addr_q;
    assign im_data     = data_q;
    assign word_count  = count_q;
    assign cpu_reset   = (state_q != LD_RUN);
    assign cpu_start   = (state_q == LD_RUN);
    assign error       = (state_q == LD_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a cycle table on the default build
// plus sequences for long loads, gaps, overflow and reset in HOLD.
module tb_program_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, va, la, rla;
    logic [15:0] da;
    logic        a_rdy, a_we, a_crst, a_start, a_err;
    logic [9:0]  a_addr;
    logic [15:0] a_data;
    logic [10:0] a_wc;

    logic        rst_b, vb, lb, rlb;
    logic [15:0] db;
    logic        b_rdy, b_we, b_crst, b_start, b_err;
    logic [3:0]  b_addr;
    logic [15:0] b_data;
    logic [4:0]  b_wc;

    program_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .RESET_CYCLES(2)) dut_a (
        .clk(clk), .reset(rst_a), .in_valid(va), .in_data(da), .in_last(la),
        .in_ready(a_rdy), .reload(rla), .im_en_write(a_we),
        .im_address(a_addr), .im_data(a_data), .cpu_reset(a_crst),
        .cpu_start(a_start), .word_count(a_wc), .error(a_err)
    );

    program_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RESET_CYCLES(1)) dut_b (
        .clk(clk), .reset(rst_b), .in_valid(vb), .in_data(db), .in_last(lb),
        .in_ready(b_rdy), .reload(rlb), .im_en_write(b_we),
        .im_address(b_addr), .im_data(b_data), .cpu_reset(b_crst),
        .cpu_start(b_start), .word_count(b_wc), .error(b_err)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [25:0] qa[$];
    logic [19:0] qb[$];

    always @(negedge clk) begin
        if (a_we === 1'b1) qa.push_back({a_addr, a_data});
        if (b_we === 1'b1) qb.push_back({b_addr, b_data});
    end

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        l;
        logic        rl;
        logic [41:0] exp;
    } vec_t;

    vec_t tbl[17];

    function automatic logic [41:0] pk(input logic rdy, input logic we,
                                       input logic [9:0] addr,
                                       input logic [15:0] data,
                                       input logic crst, input logic start,
                                       input logic [10:0] wc, input logic err);
        return {rdy, we, addr, data, crst, start, wc, err};
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d,
                        input logic l, input logic rl);
        @(negedge clk);
        va = v; da = d; la = l; rla = rl;
        #1;
    endtask

    task automatic step_b(input logic v, input logic [15:0] d,
                          input logic l, input logic rl);
        @(negedge clk);
        vb = v; db = d; lb = l; rlb = rl;
        #1;
    endtask

    logic [15:0] prog[15];

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nrdy, bad, found;

        prog = '{16'hFFFF, 16'h4004, 16'h7000, 16'h1234, 16'h8001,
                 16'h0F0F, 16'hA5A5, 16'h5A5A, 16'h3003, 16'hC00C,
                 16'h0001, 16'hFFFE, 16'h6006, 16'h9009, 16'h2400};

        //           v  data      l  rl   rdy we addr data crst st wc err
        tbl[0]  = '{0, 16'h0000, 0, 0, pk(1, 0, 10'd0, 16'h0000, 1, 0, 11'd0, 0)};
        tbl[1]  = '{1, 16'h4004, 1, 0, pk(1, 0, 10'd0, 16'h0000, 1, 0, 11'd0, 0)};
        tbl[2]  = '{0, 16'h0000, 0, 0, pk(0, 1, 10'd0, 16'h4004, 1, 0, 11'd1, 0)};
        tbl[3]  = '{0, 16'h0000, 0, 0, pk(0, 0, 10'd0, 16'h4004, 1, 0, 11'd1, 0)};
        tbl[4]  = '{0, 16'h0000, 0, 0, pk(0, 0, 10'd0, 16'h4004, 0, 1, 11'd1, 0)};
        tbl[5]  = '{1, 16'h1234, 0, 0, pk(0, 0, 10'd0, 16'h4004, 0, 1, 11'd1, 0)};
        tbl[6]  = '{0, 16'h0000, 0, 1, pk(0, 0, 10'd0, 16'h4004, 0, 1, 11'd1, 0)};
        tbl[7]  = '{0, 16'h0000, 0, 0, pk(1, 0, 10'd0, 16'h4004, 1, 0, 11'd0, 0)};
        tbl[8]  = '{1, 16'h0001, 0, 0, pk(1, 0, 10'd0, 16'h4004, 1, 0, 11'd0, 0)};
        tbl[9]  = '{1, 16'h0002, 0, 0, pk(1, 1, 10'd0, 16'h0001, 1, 0, 11'd1, 0)};
        tbl[10] = '{1, 16'h0003, 0, 1, pk(0, 1, 10'd1, 16'h0002, 1, 0, 11'd2, 0)};
        tbl[11] = '{1, 16'h0001, 0, 0, pk(1, 0, 10'd1, 16'h0002, 1, 0, 11'd0, 0)};
        tbl[12] = '{1, 16'h0002, 0, 0, pk(1, 1, 10'd0, 16'h0001, 1, 0, 11'd1, 0)};
        tbl[13] = '{1, 16'h0003, 1, 0, pk(1, 1, 10'd1, 16'h0002, 1, 0, 11'd2, 0)};
        tbl[14] = '{0, 16'h0000, 0, 0, pk(0, 1, 10'd2, 16'h0003, 1, 0, 11'd3, 0)};
        tbl[15] = '{0, 16'h0000, 0, 0, pk(0, 0, 10'd2, 16'h0003, 1, 0, 11'd3, 0)};
        tbl[16] = '{0, 16'h0000, 0, 0, pk(0, 0, 10'd2, 16'h0003, 0, 1, 11'd3, 0)};

        rst_a = 1; va = 0; da = 0; la = 0; rla = 0;
        rst_b = 1; vb = 0; db = 0; lb = 0; rlb = 0;
        repeat (3) @(negedge clk);
        rst_a = 0; rst_b = 0;

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].rl);
            check($sformatf("table row %0d", i),
                  64'(pk(a_rdy, a_we, a_addr, a_data, a_crst, a_start, a_wc, a_err)),
                  64'(tbl[i].exp));
        end

        // 15-word back-to-back load
        step(0, 0, 0, 1);
        qa.delete();
        nrdy = 0;
        for (int i = 0; i < 15; i++) begin
            step(1, prog[i], i == 14, 0);
            if (a_rdy !== 1'b1) nrdy++;
        end
        check("seqA ready", 64'(nrdy), 64'd0);
        step(0, 0, 0, 0);
        check("seqA last write", 64'({a_we, a_addr, a_wc, a_crst}),
              64'({1'b1, 10'd14, 11'd15, 1'b1}));
        step(0, 0, 0, 0);
        check("seqA hold", 64'({a_crst, a_start}), 64'(2'b10));
        step(0, 0, 0, 0);
        check("seqA run", 64'({a_crst, a_start, a_wc}), 64'({2'b01, 11'd15}));
        bad = 0;
        foreach (qa[i]) if (qa[i] !== {10'(i), prog[i]}) bad++;
        check("seqA write count", 64'(qa.size()), 64'd15);
        check("seqA write order", 64'(bad), 64'd0);

        // gapped valid, one word every third cycle
        step(0, 0, 0, 1);
        qa.delete();
        for (int i = 0; i < 5; i++) begin
            step(1, 16'hA000 + 16'(i), i == 4, 0);
            step(0, 0, 0, 0);
            step(0, 0, 0, 0);
        end
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            if (a_start === 1'b1) found = 1;
            else step(0, 0, 0, 0);
        end
        check("seqB run reached", 64'(found), 64'd1);
        bad = 0;
        foreach (qa[i]) if (qa[i] !== {10'(i), 16'hA000 + 16'(i)}) bad++;
        check("seqB write count", 64'(qa.size()), 64'd5);
        check("seqB contiguous", 64'(bad), 64'd0);
        check("seqB word_count", 64'(a_wc), 64'd5);

        // overflow on the 16-entry build
        qb.delete();
        nrdy = 0;
        for (int i = 0; i < 16; i++) begin
            step_b(1, 16'hB000 + 16'(i), 0, 0);
            if (b_rdy !== 1'b1) nrdy++;
        end
        check("seqC ready", 64'(nrdy), 64'd0);
        step_b(1, 16'hB010, 0, 0);
        check("seqC error edge",
              64'({b_rdy, b_we, b_addr, b_data, b_err, b_crst, b_start, b_wc}),
              64'({1'b0, 1'b1, 4'hF, 16'hB00F, 1'b1, 1'b1, 1'b0, 5'd16}));
        repeat (3) step_b(1, 16'hB010, 0, 0);
        check("seqC stuck", 64'({b_rdy, b_we, b_err, b_crst, b_wc}),
              64'({1'b0, 1'b0, 1'b1, 1'b1, 5'd16}));
        bad = 0;
        foreach (qb[i]) if (qb[i] !== {4'(i), 16'hB000 + 16'(i)}) bad++;
        check("seqC write count", 64'(qb.size()), 64'd16);
        check("seqC write contents", 64'(bad), 64'd0);
        step_b(0, 0, 0, 1);
        check("seqC reload cycle", 64'({b_rdy, b_err}), 64'(2'b01));
        step_b(0, 0, 0, 0);
        check("seqC after reload", 64'({b_rdy, b_err, b_crst, b_wc}),
              64'({1'b1, 1'b0, 1'b1, 5'd0}));

        // reset (with competing reload) during HOLD
        step(0, 0, 0, 1);
        step(1, 16'h1111, 0, 0);
        step(1, 16'h2222, 1, 0);
        step(0, 0, 0, 0);
        check("seqD hold", 64'({a_we, a_addr, a_data, a_crst, a_start}),
              64'({1'b1, 10'd1, 16'h2222, 1'b1, 1'b0}));
        @(negedge clk);
        rst_a = 1; rla = 1;
        #1;
        @(negedge clk);
        rst_a = 0; rla = 0;
        #1;
        check("seqD reset values",
              64'(pk(a_rdy, a_we, a_addr, a_data, a_crst, a_start, a_wc, a_err)),
              64'(pk(1, 0, 10'd0, 16'h0000, 1, 0, 11'd0, 0)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
